// File: rtl/uart_key_rx_if.sv
// Serial-in / held-key-out bundle between the keyboard UART receiver and the light stage.
interface uart_key_rx_if;
   logic       inRx;
   logic [7:0] outSel;
   logic       outValid;
   logic       outFrameErr;

   modport master (output inRx, input outSel, outValid, outFrameErr);
   modport slave  (input inRx, output outSel, outValid, outFrameErr);
endinterface

// File: rtl/uart_key_rx.sv
// UART 8N1 receiver turning keyboard key codes into a held note-select level,
// with auto-release after a hold timeout and one-shot framing-error flag.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | line idle, waiting for rxS low
// S_START | half-bit wait, re-check start bit (glitch reject)
// S_DATA  | sample 8 data bits LSB first, one per bit period
// S_STOP  | one bit period, then sample the stop bit
// S_BREAK | stop bit was low, wait for line to return high
module uart_key_rx #(
   parameter int C_CLK_FRQ  = 100_000_000,
   parameter int C_BAUD     = 115_200,
   parameter int C_HOLD_CYC = 10_000_000
) (
   input  logic          clk,
   input  logic          rstb,
   uart_key_rx_if.slave  bus
);

   localparam int BIT_CYC  = C_CLK_FRQ / C_BAUD;
   localparam int HALF_CYC = BIT_CYC / 2;
   localparam int CW       = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
   localparam int HW       = (C_HOLD_CYC > 1) ? $clog2(C_HOLD_CYC) : 1;

   localparam logic [CW-1:0] BIT_LD   = CW'(BIT_CYC - 1);
   localparam logic [CW-1:0] START_LD = CW'((HALF_CYC > 1) ? HALF_CYC - 2 : 0);
   localparam logic [HW-1:0] HOLD_TC  = HW'((C_HOLD_CYC > 0) ? C_HOLD_CYC - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t        state, stateNxt;
   logic          rxMeta, rxS;
   logic [CW-1:0] cnt, cntNxt;
   logic [2:0]    bitIdx, bitNxt;
   logic [7:0]    shiftReg, shiftNxt;
   logic [HW-1:0] holdCnt;
   logic [7:0]    selReg;
   logic          validReg, errReg;
   logic          goodFrame, frameErr;

   assign bus.outSel      = selReg;
   assign bus.outValid    = validReg;
   assign bus.outFrameErr = errReg;

   always_ff @(posedge clk or posedge rstb) begin
      if (rstb) begin
         rxMeta <= 1'b1;
         rxS    <= 1'b1;
      end else begin
         rxMeta <= bus.inRx;
         rxS    <= rxMeta;
      end
   end

   always_ff @(posedge clk or posedge rstb) begin
      if (rstb) begin
         state    <= S_IDLE;
         cnt      <= '0;
         bitIdx   <= '0;
         shiftReg <= '0;
      end else begin
         state    <= stateNxt;
         cnt      <= cntNxt;
         bitIdx   <= bitNxt;
         shiftReg <= shiftNxt;
      end
   end

   // Bit timer is a down-counter; each state acts when it hits zero.
   always_comb begin
      stateNxt  = state;
      cntNxt    = cnt;
      bitNxt    = bitIdx;
      shiftNxt  = shiftReg;
      goodFrame = 1'b0;
      frameErr  = 1'b0;
      case (state)
         S_IDLE: begin
            if (!rxS) begin
               stateNxt = S_START;
               cntNxt   = START_LD;
               bitNxt   = '0;
            end
         end
         S_START: begin
            if (cnt != '0) begin
               cntNxt = cnt - 1'b1;
            end else if (rxS) begin
               stateNxt = S_IDLE;
            end else begin
               stateNxt = S_DATA;
               cntNxt   = BIT_LD;
               bitNxt   = '0;
            end
         end
         S_DATA: begin
            if (cnt != '0) begin
               cntNxt = cnt - 1'b1;
            end else begin
               shiftNxt = {rxS, shiftReg[7:1]};
               cntNxt   = BIT_LD;
               if (bitIdx == 3'd7) begin
                  stateNxt = S_STOP;
               end else begin
                  bitNxt = bitIdx + 1'b1;
               end
            end
         end
         S_STOP: begin
            if (cnt != '0) begin
               cntNxt = cnt - 1'b1;
            end else begin
               cntNxt = '0;
               if (rxS) begin
                  goodFrame = 1'b1;
                  stateNxt  = S_IDLE;
               end else begin
                  frameErr = 1'b1;
                  stateNxt = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            if (rxS) begin
               stateNxt = S_IDLE;
            end
         end
         default: stateNxt = S_IDLE;
      endcase
   end

   // A frame landing on the expiry cycle takes priority over the auto-release.
   always_ff @(posedge clk or posedge rstb) begin
      if (rstb) begin
         selReg   <= 8'h00;
         validReg <= 1'b0;
         errReg   <= 1'b0;
         holdCnt  <= '0;
      end else begin
         validReg <= goodFrame;
         errReg   <= frameErr;
         if (goodFrame) begin
            selReg  <= shiftReg;
            holdCnt <= '0;
         end else if ((C_HOLD_CYC > 0) && (selReg != 8'h00)) begin
            if (holdCnt == HOLD_TC) begin
               selReg  <= 8'h00;
               holdCnt <= '0;
            end else begin
               holdCnt <= holdCnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_key_rx.sv
// Directed bench for uart_key_rx: 1 Mbaud at 100 MHz (100 cycles per bit), 5000-cycle hold.
module tb_uart_key_rx;

   logic clk  = 1'b0;
   logic rstb = 1'b1;

   uart_key_rx_if busIf();

   uart_key_rx #(
      .C_CLK_FRQ (100_000_000),
      .C_BAUD    (1_000_000),
      .C_HOLD_CYC(5000)
   ) dut (
      .clk (clk),
      .rstb(rstb),
      .bus (busIf)
   );

   always #5 clk = ~clk;

   int         cycle        = 0;
   int         validCnt     = 0;
   int         errCnt       = 0;
   logic [7:0] lastSel      = 8'h00;
   int         lastValidCyc = 0;
   int         tests        = 0;
   int         failed       = 0;

   always @(posedge clk) cycle <= cycle + 1;

   always @(negedge clk) begin
      if (busIf.outValid === 1'b1) begin
         validCnt++;
         lastSel      = busIf.outSel;
         lastValidCyc = cycle;
      end
      if (busIf.outFrameErr === 1'b1) errCnt++;
   end

   task automatic waitCyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sendByte(input logic [7:0] b, input logic stopBit, output int startCyc);
      startCyc   = cycle;
      busIf.inRx = 1'b0;
      waitCyc(100);
      for (int i = 0; i < 8; i++) begin
         busIf.inRx = b[i];
         waitCyc(100);
      end
      busIf.inRx = stopBit;
      waitCyc(100);
   endtask

   task automatic test_reset;
      busIf.inRx = 1'b1;
      waitCyc(3);
      tests++;
      if (busIf.outSel !== 8'h00) begin
         failed++; $display("FAIL rst_sel got %h want 00", busIf.outSel);
      end
      tests++;
      if (busIf.outValid !== 1'b0 || busIf.outFrameErr !== 1'b0) begin
         failed++; $display("FAIL rst_flags got v=%b e=%b want 0 0", busIf.outValid, busIf.outFrameErr);
      end
      rstb = 1'b0;
      waitCyc(20);
      tests++;
      if (busIf.outSel !== 8'h00 || validCnt != 0 || errCnt != 0) begin
         failed++; $display("FAIL rst_idle got sel=%h v=%0d e=%0d want 00 0 0", busIf.outSel, validCnt, errCnt);
      end
   endtask

   task automatic test_back_to_back;
      int v0, e0, s1, s2, lat;
      v0 = validCnt; e0 = errCnt;
      sendByte(8'h7A, 1'b1, s1);
      tests++;
      if (validCnt != v0 + 1 || lastSel !== 8'h7A) begin
         failed++; $display("FAIL b2b_first got cnt=%0d sel=%h want %0d 7a", validCnt, lastSel, v0 + 1);
      end
      lat = lastValidCyc - s1;
      tests++;
      if (lat < 952 || lat > 954) begin
         failed++; $display("FAIL b2b_lat1 got %0d want 952..954", lat);
      end
      sendByte(8'h73, 1'b1, s2);
      tests++;
      if (validCnt != v0 + 2 || lastSel !== 8'h73 || busIf.outSel !== 8'h73) begin
         failed++; $display("FAIL b2b_second got cnt=%0d sel=%h want %0d 73", validCnt, lastSel, v0 + 2);
      end
      lat = lastValidCyc - s2;
      tests++;
      if (lat < 952 || lat > 954) begin
         failed++; $display("FAIL b2b_lat2 got %0d want 952..954", lat);
      end
      tests++;
      if (errCnt != e0) begin
         failed++; $display("FAIL b2b_err got %0d want %0d", errCnt, e0);
      end
   endtask

   task automatic test_hold_timeout;
      int v0, s, vc;
      v0 = validCnt;
      sendByte(8'h64, 1'b1, s);
      tests++;
      if (validCnt != v0 + 1 || lastSel !== 8'h64) begin
         failed++; $display("FAIL hold_rx got cnt=%0d sel=%h want %0d 64", validCnt, lastSel, v0 + 1);
      end
      vc = lastValidCyc;
      while (cycle < vc + 4999) @(negedge clk);
      tests++;
      if (busIf.outSel !== 8'h64) begin
         failed++; $display("FAIL hold_last got %h want 64", busIf.outSel);
      end
      @(negedge clk);
      tests++;
      if (busIf.outSel !== 8'h00) begin
         failed++; $display("FAIL hold_expire got %h want 00", busIf.outSel);
      end
      while (cycle < s + 7000) @(negedge clk);
      tests++;
      if (validCnt != v0 + 1 || busIf.outSel !== 8'h00) begin
         failed++; $display("FAIL hold_quiet got cnt=%0d sel=%h want %0d 00", validCnt, busIf.outSel, v0 + 1);
      end
   endtask

   task automatic test_release;
      int v0, s;
      v0 = validCnt;
      sendByte(8'h63, 1'b1, s);
      tests++;
      if (busIf.outSel !== 8'h63) begin
         failed++; $display("FAIL rel_key got %h want 63", busIf.outSel);
      end
      sendByte(8'h00, 1'b1, s);
      tests++;
      if (validCnt != v0 + 2 || lastSel !== 8'h00 || busIf.outSel !== 8'h00) begin
         failed++; $display("FAIL rel_zero got cnt=%0d sel=%h want %0d 00", validCnt, busIf.outSel, v0 + 2);
      end
   endtask

   task automatic test_glitch;
      int v0, e0, s;
      sendByte(8'h41, 1'b1, s);
      v0 = validCnt; e0 = errCnt;
      busIf.inRx = 1'b0;
      waitCyc(30);
      busIf.inRx = 1'b1;
      waitCyc(200);
      tests++;
      if (validCnt != v0 || errCnt != e0 || busIf.outSel !== 8'h41) begin
         failed++; $display("FAIL glitch got v=%0d e=%0d sel=%h want %0d %0d 41", validCnt, errCnt, busIf.outSel, v0, e0);
      end
   endtask

   task automatic test_frame_err;
      int v0, e0, s;
      v0 = validCnt; e0 = errCnt;
      sendByte(8'h76, 1'b0, s);
      waitCyc(500);
      tests++;
      if (errCnt != e0 + 1 || validCnt != v0 || busIf.outSel !== 8'h41) begin
         failed++; $display("FAIL ferr_bad got e=%0d v=%0d sel=%h want %0d %0d 41", errCnt, validCnt, busIf.outSel, e0 + 1, v0);
      end
      busIf.inRx = 1'b1;
      waitCyc(20);
      sendByte(8'h67, 1'b1, s);
      tests++;
      if (errCnt != e0 + 1 || validCnt != v0 + 1 || lastSel !== 8'h67 || busIf.outSel !== 8'h67) begin
         failed++; $display("FAIL ferr_recover got e=%0d v=%0d sel=%h want %0d %0d 67", errCnt, validCnt, busIf.outSel, e0 + 1, v0 + 1);
      end
   endtask

   task automatic test_reset_mid_frame;
      int v0, e0, s;
      v0 = validCnt; e0 = errCnt;
      busIf.inRx = 1'b0;
      waitCyc(100);
      busIf.inRx = 1'b1;
      waitCyc(350);
      rstb = 1'b1;
      #1;
      tests++;
      if (busIf.outSel !== 8'h00 || busIf.outValid !== 1'b0 || busIf.outFrameErr !== 1'b0) begin
         failed++; $display("FAIL midrst_async got sel=%h v=%b e=%b want 00 0 0", busIf.outSel, busIf.outValid, busIf.outFrameErr);
      end
      waitCyc(10);
      rstb = 1'b0;
      waitCyc(700);
      tests++;
      if (validCnt != v0 || errCnt != e0 || busIf.outSel !== 8'h00) begin
         failed++; $display("FAIL midrst_partial got v=%0d e=%0d sel=%h want %0d %0d 00", validCnt, errCnt, busIf.outSel, v0, e0);
      end
      sendByte(8'h62, 1'b1, s);
      tests++;
      if (validCnt != v0 + 1 || lastSel !== 8'h62) begin
         failed++; $display("FAIL midrst_next got cnt=%0d sel=%h want %0d 62", validCnt, lastSel, v0 + 1);
      end
   endtask

   initial begin
      #900us;
      failed++;
      $display("FAIL watchdog time limit reached at cycle %0d", cycle);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $fatal(1, "watchdog");
   end

   initial begin
      busIf.inRx = 1'b1;
      @(negedge clk);
      test_reset();
      test_back_to_back();
      test_hold_timeout();
      test_release();
      test_glitch();
      test_frame_err();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
